// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence interface: FSM state encoding and
// default geometry, common to the pattern transmitter, the detector and benches.
package seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      GAP   = 2'b10,
      DONE  = 2'b11
   } seq_state_t;

   localparam int SEQ_PAT_W   = 8;
   localparam int SEQ_CNT_W   = 4;
   localparam int SEQ_GAP_LEN = 2;

endpackage

// File: rtl/seq_shift_reg.sv
// Loadable PAT_W-bit left-shift register with MSB-first taps and a bit-index
// down-counter; last is high while the final bit of the pattern is at the MSB.
module seq_shift_reg
   import seq_pkg::*;
#(
   parameter int PAT_W = SEQ_PAT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] din,
   output logic             msb,
   output logic             nxt,
   output logic             last
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   logic [PAT_W-1:0] sr;
   logic [BW-1:0]    bcnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr   <= '0;
         bcnt <= '0;
      end else if (load) begin
         sr   <= din;
         bcnt <= BW'(PAT_W - 1);
      end else if (shift) begin
         sr   <= {sr[PAT_W-2:0], 1'b0};
         bcnt <= bcnt - 1'b1;
      end
   end

   assign msb  = sr[PAT_W-1];
   // nxt is the bit that becomes MSB after the next shift, so x can be registered
   assign nxt  = sr[PAT_W-2];
   assign last = (bcnt == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter feeding a sequence detector, MSB first.
// Define SEQ_PATTERN_TX_GAP_EN to insert GAP_LEN idle cycles between repetitions.
module seq_pattern_tx
   import seq_pkg::*;
#(
   parameter int PAT_W   = SEQ_PAT_W,
   parameter int CNT_W   = SEQ_CNT_W,
   parameter int GAP_LEN = SEQ_GAP_LEN
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] rep,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   if (PAT_W < 2)   begin : g_bad_pat $error("PAT_W must be at least 2"); end
   if (GAP_LEN < 1) begin : g_bad_gap $error("GAP_LEN must be at least 1"); end

   seq_state_t       state;
   logic [PAT_W-1:0] pat_q;
   logic [CNT_W-1:0] rcnt;
   logic             ld, sh;
   logic [PAT_W-1:0] ld_data;
   logic             sr_msb, sr_nxt, sr_last;
   logic             more;

`ifdef SEQ_PATTERN_TX_GAP_EN
   localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
   logic [GW-1:0] gcnt;
`endif

   // another repetition follows the one whose last bit is on the line
   assign more = (rcnt != CNT_W'(1));

   always_comb begin
      ld      = 1'b0;
      sh      = 1'b0;
      ld_data = pat_q;
      case (state)
         IDLE:  if (start) begin
                   ld      = 1'b1;
                   ld_data = pattern;
                end
         SHIFT: if (!sr_last) sh = 1'b1;
                else if (more) ld = 1'b1;
         default: ;
      endcase
   end

   seq_shift_reg #(.PAT_W(PAT_W)) u_sr (
      .clk   (clk),
      .reset (reset),
      .load  (ld),
      .shift (sh),
      .din   (ld_data),
      .msb   (sr_msb),
      .nxt   (sr_nxt),
      .last  (sr_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pat_q <= '0;
         rcnt  <= '0;
         x     <= 1'b0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef SEQ_PATTERN_TX_GAP_EN
         gcnt  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  pat_q <= pattern;
                  rcnt  <= rep;
                  if (rep != '0) begin
                     state <= SHIFT;
                     x     <= pattern[PAT_W-1];
                     valid <= 1'b1;
                     busy  <= 1'b1;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (!sr_last) begin
                  x <= sr_nxt;
               end else begin
                  rcnt <= rcnt - 1'b1;
                  if (!more) begin
                     state <= DONE;
                     x     <= 1'b0;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
`ifdef SEQ_PATTERN_TX_GAP_EN
                     state <= GAP;
                     x     <= 1'b0;
                     valid <= 1'b0;
                     gcnt  <= GW'(GAP_LEN - 1);
`else
                     x     <= pat_q[PAT_W-1];
`endif
                  end
               end
            end
`ifdef SEQ_PATTERN_TX_GAP_EN
            GAP: begin
               if (gcnt == '0) begin
                  state <= SHIFT;
                  x     <= sr_msb;
                  valid <= 1'b1;
               end else begin
                  gcnt <= gcnt - 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               x     <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

`ifndef SEQ_PATTERN_TX_GAP_EN
   // shift register MSB is only needed to restart after a gap
   logic unused_msb;
   assign unused_msb = sr_msb;
`endif

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: cycle-exact checks of x/valid/busy/done
// across repeat counts, ignored starts, mid-transfer reset and held start.
module tb_seq_pattern_tx;
   import seq_pkg::*;

`ifdef SEQ_PATTERN_TX_GAP_EN
   localparam int G = 2;
`else
   localparam int G = 0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] rep = '0;
   logic       x, valid, busy, done;

   int n_vec = 0;
   int n_bad = 0;

   seq_pattern_tx #(.PAT_W(8), .CNT_W(4), .GAP_LEN(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .rep     (rep),
      .x       (x),
      .valid   (valid),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one transfer; {x,valid,busy,done} checked every cycle up to the
   // cycle after done. A start with pattern FF is poked during cycle 'poke'.
   task automatic run_xfer(input logic [7:0] pat, input logic [3:0] r, input int poke);
      int d, per, w;
      logic [3:0] e;
      d   = (r == 0) ? 1 : 1 + r * 8 + (r - 1) * G;
      per = 8 + G;
      pattern = pat; rep = r; start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c <= d + 1; c++) begin
         if (c == d)      e = 4'b0001;
         else if (c > d)  e = 4'b0000;
         else begin
            w = (c - 1) % per;
            e = (w < 8) ? {pat[7 - w], 3'b110} : 4'b0010;
         end
         chk($sformatf("xfer %0h r%0d c%0d", pat, r, c), {28'b0, x, valid, busy, done}, {28'b0, e});
         if (c == poke) begin
            start = 1'b1; pattern = 8'hFF; rep = 4'd5;
         end
         tick();
         if (c == poke) begin
            start = 1'b0; pattern = pat; rep = r;
         end
      end
   endtask

   logic [7:0] bits;

   initial begin
      #2;
      chk("reset outs", {28'b0, x, valid, busy, done}, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("idle outs", {28'b0, x, valid, busy, done}, 32'h0);

      // explicit hand-computed serial stream for 1001_0110
      bits = 8'b1001_0110;
      pattern = bits; rep = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("c1 bit", {31'b0, x}, 32'd1);
      tick(); chk("c2 bit", {31'b0, x}, 32'd0);
      tick(); chk("c3 bit", {31'b0, x}, 32'd0);
      tick(); chk("c4 bit", {31'b0, x}, 32'd1);
      tick(); tick(); tick(); tick();
      chk("c8 bit valid", {30'b0, x, valid}, 32'b01);
      tick();
      chk("c9 done", {28'b0, x, valid, busy, done}, 32'b0001);
      tick();
      chk("c10 idle", {28'b0, x, valid, busy, done}, 32'b0000);

      run_xfer(8'b1001_0110, 4'd1, 0);
      run_xfer(8'b1001_0110, 4'd3, 0);
      run_xfer(8'hA5, 4'd0, 0);
      run_xfer(8'h3C, 4'd2, 0);
      run_xfer(8'h81, 4'd15, 0);
      run_xfer(8'b1001_0110, 4'd2, 3);   // start during SHIFT ignored

      // reset mid-transfer in cycle 4
      pattern = 8'hF0; rep = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("c4 pre-reset", {28'b0, x, valid, busy, done}, 32'b1110);
      #2 reset = 1'b1;
      #1 chk("async reset", {28'b0, x, valid, busy, done}, 32'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("post-reset idle", {28'b0, x, valid, busy, done}, 32'h0);
      end
      run_xfer(8'h5A, 4'd1, 0);

      // start held: done in cycle 9, IDLE in 10, next first bit in 11
      pattern = 8'hC3; rep = 4'd1; start = 1'b1;
      tick();
      for (int c = 1; c < 9; c++) tick();
      chk("held done c9", {28'b0, x, valid, busy, done}, 32'b0001);
      tick();
      chk("held idle c10", {28'b0, x, valid, busy, done}, 32'b0000);
      tick();
      start = 1'b0;
      chk("held restart c11", {28'b0, x, valid, busy, done}, 32'b1110);
      for (int c = 11; c < 19; c++) tick();
      chk("held done c19", {28'b0, x, valid, busy, done}, 32'b0001);
      tick();
      chk("held idle c20", {28'b0, x, valid, busy, done}, 32'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial bit-pattern transmitter: the driving end of the team's single-bit Moore sequence-detector interface. On a start request it captures a PAT_W-bit pattern and a repeat count, then shifts the pattern out MSB-first on a registered serial line, one bit per clock, optionally separated by idle gaps. It sits ahead of a detector and replaces hand-written stimulus: the detector's serial input is fed directly from `x`.

## Interface
- PAT_W, 8, pattern width in bits (≥2)
- CNT_W, 4, repeat-count width
- GAP_LEN, 2, idle cycles between repetitions (used only with gap feature; ≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- pattern  in  PAT_W  pattern, captured on accepted start
- rep  in  CNT_W  number of repetitions, captured on accepted start
- x  out  1  serial data, registered, MSB first
- valid  out  1  high while x carries a pattern bit
- busy  out  1  high from the cycle after an accepted start until the last bit is sent
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, SHIFT, GAP, DONE. Moore: all outputs are registered functions of state and shift register only.
- IDLE: x=0, valid=0, busy=0, done=0. start=1 at a clock edge → capture pattern into shift register, rep into repeat counter, bit counter := PAT_W-1; go SHIFT (rep≠0) or DONE (rep=0).
- SHIFT: x = shift_reg[PAT_W-1], valid=1, busy=1. Each edge shifts left by one and decrements bit counter. On the edge where the bit counter is 0: decrement repeat counter; if remaining reps=0 → DONE; else reload pattern from the captured copy and go GAP (gap feature on) or stay in SHIFT (gap feature off, back-to-back).
- GAP: x=0, valid=0, busy=1; GAP_LEN cycles, then SHIFT with reloaded pattern.
- DONE: done=1, busy=0, x=0, valid=0; exactly one cycle, then IDLE unconditionally.
- start outside IDLE is ignored, never queued. pattern/rep changes after capture have no effect.
- start held high continuously: new transfer accepted on the first IDLE edge after DONE (one IDLE cycle between transfers).
- Repeat counter is CNT_W bits, no wrap: rep = 2^CNT_W-1 sends exactly that many repetitions.

## Timing
- Reset (any time, including mid-SHIFT/GAP): state IDLE, x=0, valid=0, busy=0, done=0, counters and shift register cleared, asynchronously; no done pulse for the aborted transfer.
- Start accepted at edge E0 → first bit on x during cycle after E0 (latency 1).
- Each bit held exactly one cycle.
- done high in cycle 1 + rep·PAT_W + (rep−1)·G after E0, where G=GAP_LEN with gap feature, else 0. rep=0 → done in cycle 1.
- Total valid-high cycles = rep·PAT_W.

## Configuration
- SEQ_PATTERN_TX_GAP_EN defined: GAP state present; GAP_LEN idle zero cycles inserted between consecutive repetitions (never before the first or after the last).
- Undefined: GAP state and gap counter not compiled; repetitions are back-to-back, valid stays high continuously across repetitions; GAP_LEN ignored.

## Structure
- Shared package seq_pkg: state enum (IDLE, SHIFT, GAP, DONE) and its 2-bit encoding, default PAT_W/CNT_W/GAP_LEN constants, shared with the detector and benches.
- One sub-module, seq_shift_reg: loadable PAT_W-bit left-shift register with MSB output and bit-index down-counter, exposing a last-bit flag.

## Test plan
- PAT_W=8, pattern 8'b1001_0110, rep=1, start pulse at E0 → x = 1,0,0,1,0,1,1,0 in cycles 1–8, valid 1 for those 8 cycles, done pulse in cycle 9, busy 0 in cycle 9.
- Same pattern, rep=3, gap on, GAP_LEN=2 → three 8-bit bursts with 2 cycles x=0/valid=0 between, done in cycle 29; gap off → 24 continuous valid cycles, done in cycle 25.
- rep=0 → no valid cycles, done in cycle 1, IDLE in cycle 2.
- start pulsed again during SHIFT with pattern 8'hFF → ignored; original sequence unchanged, single done pulse.
- reset asserted mid-transfer in cycle 4 → x, valid, busy drop to 0 immediately, no done; a later start transmits normally.
- start held high, rep=1 → transfers repeat with exactly one IDLE cycle between done and the next first bit.
